// File: rtl/alu_mem_subsystem.sv
// Execution/storage core: byte-loaded instruction memory, data memory and a clocked ALU.
// Optional multiplier enabled by defining ALU_MUL_EN (op 01101 is a no-op otherwise).
module alu_mem_subsystem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              button,
    input  logic [7:0]        input_instruction,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              imem_full,
    input  logic [ADDR_W-1:0] dm_read_addr,
    input  logic [ADDR_W-1:0] dm_write_addr,
    input  logic              dm_read_enable,
    input  logic              dm_write_enable,
    input  logic [DATA_W-1:0] dm_write_data,
    output logic [DATA_W-1:0] dm_read_data,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] accumulator,
    output logic              carry,
    output logic              overflow,
    output logic              bool,
    output logic              zero
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] imem_q [DEPTH];
    logic [DATA_W-1:0] dmem_q [DEPTH];
    logic [ADDR_W:0]   ptr_q;
    logic [7:0]        hi_q;
    logic              toggle_q;
    logic              sync1_q, sync2_q, prev_q;
    logic              press, load_fire;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d, ov_q, ov_d, bool_q, bool_d, zero_q, zero_d;
    logic              acc_we;
    logic [1:0]        alu_type;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
`ifdef ALU_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    // A press is the rising edge of the synchronized button level.
    assign press     = sync2_q & ~prev_q;
    assign load_fire = press & ~clk_enable & ~ptr_q[ADDR_W];
    assign imem_full = ptr_q[ADDR_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            ptr_q    <= '0;
            hi_q     <= '0;
            toggle_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) imem_q[i] <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (load_fire) begin
                if (!toggle_q) begin
                    hi_q     <= input_instruction;
                    toggle_q <= 1'b1;
                end else begin
                    imem_q[ptr_q[ADDR_W-1:0]] <= {hi_q, input_instruction};
                    ptr_q    <= ptr_q + 1'b1;
                    toggle_q <= 1'b0;
                end
            end
        end
    end

    assign instruction = imem_q[pc];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) dmem_q[i] <= '0;
        end else if (clk_enable && dm_write_enable) begin
            dmem_q[dm_write_addr] <= dm_write_data;
        end
    end

    assign dm_read_data = dm_read_enable ? dmem_q[dm_read_addr] : '0;

    assign alu_type = instruction[15:14];
    assign alu_op   = instruction[13:9];
    // INC shares the adder with ADD by forcing operand B to one.
    assign add_b    = (alu_op == 5'b00011) ? DATA_W'(1) : alu_b;
    assign sum      = {1'b0, alu_a} + {1'b0, add_b};
    assign diff     = alu_a - alu_b;
`ifdef ALU_MUL_EN
    assign prod     = alu_a * alu_b;
`endif

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        ov_d    = ov_q;
        bool_d  = bool_q;
        acc_we  = 1'b0;
        if (clk_enable && !alu_type[1]) begin
            case (alu_op)
                5'b00000, 5'b00011: begin
                    acc_d   = sum[DATA_W-1:0];
                    carry_d = sum[DATA_W];
                    ov_d    = (alu_a[DATA_W-1] == add_b[DATA_W-1]) &&
                              (sum[DATA_W-1] != alu_a[DATA_W-1]);
                    acc_we  = 1'b1;
                end
                5'b00001: begin
                    acc_d   = diff;
                    carry_d = alu_a < alu_b;
                    ov_d    = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                              (diff[DATA_W-1] != alu_a[DATA_W-1]);
                    acc_we  = 1'b1;
                end
                5'b00100: begin acc_d = alu_a & alu_b;       carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                5'b00101: begin acc_d = alu_a | alu_b;       carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                5'b00110: begin acc_d = alu_a ^ alu_b;       carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                5'b00111: begin acc_d = ~alu_a;              carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                5'b01000: begin acc_d = alu_a << alu_b[3:0]; carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                5'b01001: begin acc_d = alu_a >> alu_b[3:0]; carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                5'b01010: bool_d = (alu_a == alu_b);
                5'b01011: bool_d = (alu_a < alu_b);
                5'b01100: bool_d = (alu_a > alu_b);
`ifdef ALU_MUL_EN
                5'b01101: begin
                    acc_d   = prod[DATA_W-1:0];
                    carry_d = |prod[2*DATA_W-1:DATA_W];
                    ov_d    = |prod[2*DATA_W-1:DATA_W];
                    acc_we  = 1'b1;
                end
`endif
                5'b01110: begin acc_d = alu_a; carry_d = 1'b0; ov_d = 1'b0; acc_we = 1'b1; end
                default: ;
            endcase
        end
        zero_d = acc_we ? (acc_d == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            ov_q    <= 1'b0;
            bool_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ov_q    <= ov_d;
            bool_q  <= bool_d;
            zero_q  <= zero_d;
        end
    end

    assign accumulator = acc_q;
    assign carry       = carry_q;
    assign overflow    = ov_q;
    assign bool        = bool_q;
    assign zero        = zero_q;
endmodule

// File: tb/tb_alu_mem_subsystem.sv
// Bench for alu_mem_subsystem: instruction loading, data memory, ALU vectors, async reset.
module tb_alu_mem_subsystem;
  localparam int W = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic        button = 1'b0;
  logic [7:0]  input_instruction = '0;
  logic [5:0]  pc = '0;
  logic [15:0] instruction;
  logic        imem_full;
  logic [5:0]  dm_read_addr = '0, dm_write_addr = '0;
  logic        dm_read_enable = 1'b0, dm_write_enable = 1'b0;
  logic [15:0] dm_write_data = '0, dm_read_data;
  logic [15:0] alu_a = '0, alu_b = '0, accumulator;
  logic        carry, overflow, bool, zero;

  alu_mem_subsystem dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .button(button),
    .input_instruction(input_instruction), .pc(pc), .instruction(instruction),
    .imem_full(imem_full), .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr),
    .dm_read_enable(dm_read_enable), .dm_write_enable(dm_write_enable),
    .dm_write_data(dm_write_data), .dm_read_data(dm_read_data),
    .alu_a(alu_a), .alu_b(alu_b), .accumulator(accumulator),
    .carry(carry), .overflow(overflow), .bool(bool), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        ce;
    logic [5:0]  pcv;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] acc;
    logic        c;
    logic        v;
    logic        bl;
    logic        z;
  } vec_t;

  vec_t vecs[21];
  logic [15:0] prog[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Press with byte held; the press lands on the 3rd posedge after button rises.
  task automatic press(input logic [7:0] byte_v);
    input_instruction = byte_v;
    button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic alu_step(input vec_t v, input int idx);
    logic [W-1:0] e;
    clk_enable = v.ce;
    pc = v.pcv;
    alu_a = v.a;
    alu_b = v.b;
    exp_q.push_back({v.acc, v.c, v.v, v.bl, v.z});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL alu_vec%0d: scoreboard empty", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("alu_vec%0d", idx), {12'h0, accumulator, carry, overflow, bool, zero}, {12'h0, e});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
    prog[0] = 16'h0005; prog[1] = 16'h0203; prog[2] = 16'h0600; prog[3] = 16'h0800;
    prog[4] = 16'h0A00; prog[5] = 16'h0C00; prog[6] = 16'h0E00; prog[7] = 16'h1000;
    prog[8] = 16'h1200; prog[9] = 16'h1400; prog[10] = 16'h1600; prog[11] = 16'h1800;
    prog[12] = 16'h1A00; prog[13] = 16'h1C00; prog[14] = 16'h8000; prog[15] = 16'h4000;
    prog[16] = 16'h0400;

    //             ce  pc     a         b         acc       c  v  bl z
    vecs[0]  = '{1'b1, 6'd0,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 1};
    vecs[1]  = '{1'b1, 6'd0,  16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 0};
    vecs[2]  = '{1'b1, 6'd1,  16'h0003, 16'h0005, 16'hFFFE, 1, 0, 0, 0};
    vecs[3]  = '{1'b1, 6'd9,  16'h0007, 16'h0007, 16'hFFFE, 1, 0, 1, 0};
    vecs[4]  = '{1'b1, 6'd10, 16'h0005, 16'h0003, 16'hFFFE, 1, 0, 0, 0};
    vecs[5]  = '{1'b1, 6'd11, 16'h8000, 16'h7FFF, 16'hFFFE, 1, 0, 1, 0};
    vecs[6]  = '{1'b1, 6'd2,  16'hFFFF, 16'h0000, 16'h0000, 1, 0, 1, 1};
    vecs[7]  = '{1'b1, 6'd2,  16'h7FFF, 16'h1234, 16'h8000, 0, 1, 1, 0};
    vecs[8]  = '{1'b1, 6'd3,  16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 1, 0};
    vecs[9]  = '{1'b1, 6'd4,  16'hF000, 16'h000F, 16'hF00F, 0, 0, 1, 0};
    vecs[10] = '{1'b1, 6'd5,  16'hAAAA, 16'hAAAA, 16'h0000, 0, 0, 1, 1};
    vecs[11] = '{1'b1, 6'd6,  16'h00FF, 16'h0000, 16'hFF00, 0, 0, 1, 0};
    vecs[12] = '{1'b1, 6'd7,  16'h0001, 16'h0013, 16'h0008, 0, 0, 1, 0};
    vecs[13] = '{1'b1, 6'd8,  16'h8000, 16'h000F, 16'h0001, 0, 0, 1, 0};
    vecs[14] = '{1'b1, 6'd13, 16'h1234, 16'h5678, 16'h1234, 0, 0, 1, 0};
    vecs[15] = '{1'b1, 6'd14, 16'h0001, 16'h0001, 16'h1234, 0, 0, 1, 0};
    vecs[16] = '{1'b1, 6'd16, 16'h0001, 16'h0001, 16'h1234, 0, 0, 1, 0};
    vecs[17] = '{1'b1, 6'd15, 16'h8000, 16'h8000, 16'h0000, 1, 1, 1, 1};
    vecs[18] = '{1'b1, 6'd1,  16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1, 0};
`ifdef ALU_MUL_EN
    vecs[19] = '{1'b1, 6'd12, 16'h0100, 16'h0100, 16'h0000, 1, 1, 1, 1};
    vecs[20] = '{1'b0, 6'd0,  16'h0001, 16'h0001, 16'h0000, 1, 1, 1, 1};
`else
    vecs[19] = '{1'b1, 6'd12, 16'h0100, 16'h0100, 16'h7FFF, 0, 1, 1, 0};
    vecs[20] = '{1'b0, 6'd0,  16'h0001, 16'h0001, 16'h7FFF, 0, 1, 1, 0};
`endif

    // Reset state
    #1;
    check("rst_acc_flags", {12'h0, accumulator, carry, overflow, bool, zero}, 32'h0);
    check("rst_imem_full", {31'h0, imem_full}, 32'h0);
    check("rst_instruction", {16'h0, instruction}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Halted loading of the first two words
    press(8'h00); press(8'h05); press(8'h02); press(8'h03);
    pc = 6'd0; #1;
    check("load_word0", {16'h0, instruction}, 32'h0005);
    pc = 6'd1; #1;
    check("load_word1", {16'h0, instruction}, 32'h0203);

    // Presses while running are ignored
    pc = 6'd2;
    clk_enable = 1'b1;
    press(8'h12); press(8'h34);
    clk_enable = 1'b0;
    check("load_ignored_running", {16'h0, instruction}, 32'h0000);

    for (int i = 2; i < 64; i++) begin
      press(prog[i][15:8]);
      press(prog[i][7:0]);
      if (i == 62) check("imem_not_full_62", {31'h0, imem_full}, 32'h0);
    end
    check("imem_full_64", {31'h0, imem_full}, 32'h1);
    pc = 6'd2; #1;
    check("load_word2_after_ignored", {16'h0, instruction}, 32'h0600);
    pc = 6'd16; #1;
    check("load_word16", {16'h0, instruction}, 32'h0400);
    press(8'hFF); press(8'hEE);
    pc = 6'd0; #1;
    check("full_no_wrap_word0", {16'h0, instruction}, 32'h0005);

    // ALU vectors
    for (int i = 0; i < 21; i++) alu_step(vecs[i], i);

    // Data memory: same-address read returns old data, then the new value
    clk_enable = 1'b1;
    pc = 6'd14;
    dm_read_enable = 1'b1; dm_read_addr = 6'd63;
    dm_write_enable = 1'b1; dm_write_addr = 6'd63; dm_write_data = 16'hBEEF;
    #1;
    check("dm_same_addr_old", {16'h0, dm_read_data}, 32'h0000);
    @(posedge clk);
    #1;
    dm_write_enable = 1'b0;
    #1;
    check("dm_read_63", {16'h0, dm_read_data}, 32'hBEEF);
    dm_read_enable = 1'b0;
    #1;
    check("dm_read_disabled", {16'h0, dm_read_data}, 32'h0000);
    clk_enable = 1'b0;
    dm_write_enable = 1'b1; dm_write_addr = 6'd5; dm_write_data = 16'h1111;
    @(posedge clk);
    #1;
    dm_write_enable = 1'b0;
    dm_read_enable = 1'b1; dm_read_addr = 6'd5;
    #1;
    check("dm_write_halted", {16'h0, dm_read_data}, 32'h0000);

    // Mid-cycle asynchronous reset with accumulator = 0x1234
    alu_step('{1'b1, 6'd13, 16'h1234, 16'h0000, 16'h1234, 0, 0, 1, 0}, 21);
    dm_read_addr = 6'd63;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_acc_flags", {12'h0, accumulator, carry, overflow, bool, zero}, 32'h0);
    check("async_rst_dmem", {16'h0, dm_read_data}, 32'h0000);
    pc = 6'd1; #1;
    check("async_rst_imem", {16'h0, instruction}, 32'h0000);
    check("async_rst_full", {31'h0, imem_full}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
